// File: rtl/mod_mul_arbiter.sv
// mod_mul_arbiter: round-robin front end for a shared pipelined
// Barrett modular multiplier, with tag-based result routing.
module mod_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 10,
  parameter int WIDTH   = 32
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic [NUM_REQ-1:0]       iReqValid,
  output logic [NUM_REQ-1:0]       oReqReady,
  input  logic [NUM_REQ*WIDTH-1:0] iReqData0,
  input  logic [NUM_REQ*WIDTH-1:0] iReqData1,
  output logic [NUM_REQ-1:0]       oRspValid,
  output logic [WIDTH-1:0]         oRspData,
  input  logic                     iCfgValid,
  input  logic [WIDTH-1:0]         iCfgMod,
  input  logic [2*WIDTH-1:0]       iCfgU,
  output logic                     oCfgReady,
  output logic                     oBusy,
  output logic                     oMulEn,
  output logic                     oMulClr,
  output logic [WIDTH-1:0]         oMulData0,
  output logic [WIDTH-1:0]         oMulData1,
  output logic [WIDTH-1:0]         oMulMod,
  output logic [2*WIDTH-1:0]       oMulU,
  input  logic [WIDTH-1:0]         iMulData
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LATENCY + 2);

  localparam logic [1:0] S_UNCFG = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [IW-1:0]               ptr_q, ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [LATENCY:0]            tag_vld_q;
  logic [LATENCY:0][IW-1:0]    tag_idx_q;
  logic [NUM_REQ-1:0]          rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0]            rsp_data_q;
  logic [WIDTH-1:0]            mul_a_q, mul_b_q;
  logic [WIDTH-1:0]            mod_q;
  logic [2*WIDTH-1:0]          u_q;
  logic                        en_q, clr_q;

  logic                        gnt_any;
  logic [IW-1:0]               gnt_idx;
  logic [IW:0]                 pos;
  logic [IW:0]                 nxt;
  logic [NUM_REQ-1:0]          gnt;
  logic [WIDTH-1:0]            op_a, op_b;
  logic                        retire;
  logic                        drained;
  logic                        cfg_acc;

  // Wrapping search starting at the pointer; no grant while cfg waits.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    if (state_q == S_RUN && !iCfgValid) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        pos = {1'b0, ptr_q} + (IW+1)'(k);
        if (pos >= (IW+1)'(NUM_REQ))
          pos = pos - (IW+1)'(NUM_REQ);
        if (!gnt_any && iReqValid[pos[IW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = pos[IW-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt  = '0;
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_any && gnt_idx == IW'(k)) begin
        gnt[k] = 1'b1;
        op_a   = iReqData0[k*WIDTH +: WIDTH];
        op_b   = iReqData1[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, gnt_idx} + 1'b1;
    if (nxt == (IW+1)'(NUM_REQ))
      nxt = '0;
    ptr_d = gnt_any ? nxt[IW-1:0] : ptr_q;
  end

  assign retire  = tag_vld_q[LATENCY];
  assign drained = (cnt_q == '0) && !(|rsp_vld_q);
  assign cfg_acc = iCfgValid &&
                   (state_q == S_UNCFG ||
                    (state_q == S_DRAIN && drained));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_UNCFG: if (cfg_acc)   state_d = S_RUN;
      S_RUN:   if (iCfgValid) state_d = S_DRAIN;
      S_DRAIN: if (cfg_acc)   state_d = S_RUN;
      default:                state_d = S_UNCFG;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CW'(gnt_any) - CW'(retire);
    rsp_vld_d = '0;
    if (retire)
      rsp_vld_d[tag_idx_q[LATENCY]] = 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q    <= S_UNCFG;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mod_q      <= '0;
      u_q        <= '0;
      en_q       <= 1'b0;
      clr_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= {tag_vld_q[LATENCY-1:0], gnt_any};
      tag_idx_q <= {tag_idx_q[LATENCY-1:0], gnt_idx};
      rsp_vld_q <= rsp_vld_d;
      en_q      <= 1'b1;
      clr_q     <= cfg_acc;
      if (retire)
        rsp_data_q <= iMulData;
      if (gnt_any) begin
        mul_a_q <= op_a;
        mul_b_q <= op_b;
      end
      if (cfg_acc) begin
        mod_q <= iCfgMod;
        u_q   <= iCfgU;
      end
    end
  end

  assign oReqReady = gnt;
  assign oCfgReady = cfg_acc;
  assign oRspValid = rsp_vld_q;
  assign oRspData  = rsp_data_q;
  assign oBusy     = (cnt_q != '0);
  assign oMulEn    = en_q;
  assign oMulClr   = clr_q;
  assign oMulData0 = mul_a_q;
  assign oMulData1 = mul_b_q;
  assign oMulMod   = mod_q;
  assign oMulU     = u_q;

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// tb_mod_mul_arbiter: random stimulus against a queue-based
// transaction model of the shared multiplier arbiter.
module tb_mod_mul_arbiter;

  localparam int N = 4;
  localparam int L = 10;
  localparam int W = 32;

  localparam int UNCFG = 0;
  localparam int RUN   = 1;
  localparam int DRAIN = 2;

  logic             clk;
  logic             iRstN;
  logic [N-1:0]     iReqValid;
  logic [N-1:0]     oReqReady;
  logic [N*W-1:0]   iReqData0;
  logic [N*W-1:0]   iReqData1;
  logic [N-1:0]     oRspValid;
  logic [W-1:0]     oRspData;
  logic             iCfgValid;
  logic [W-1:0]     iCfgMod;
  logic [2*W-1:0]   iCfgU;
  logic             oCfgReady;
  logic             oBusy;
  logic             oMulEn;
  logic             oMulClr;
  logic [W-1:0]     oMulData0;
  logic [W-1:0]     oMulData1;
  logic [W-1:0]     oMulMod;
  logic [2*W-1:0]   oMulU;
  logic [W-1:0]     iMulData;

  logic [W-1:0]     da[N];
  logic [W-1:0]     db[N];
  logic [W-1:0]     mpipe[L];

  mod_mul_arbiter #(
    .NUM_REQ(N), .LATENCY(L), .WIDTH(W)
  ) dut (
    .iClk(clk), .iRstN(iRstN),
    .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqData0(iReqData0), .iReqData1(iReqData1),
    .oRspValid(oRspValid), .oRspData(oRspData),
    .iCfgValid(iCfgValid), .iCfgMod(iCfgMod),
    .iCfgU(iCfgU), .oCfgReady(oCfgReady),
    .oBusy(oBusy), .oMulEn(oMulEn), .oMulClr(oMulClr),
    .oMulData0(oMulData0), .oMulData1(oMulData1),
    .oMulMod(oMulMod), .oMulU(oMulU),
    .iMulData(iMulData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      iReqData0[k*W +: W] = da[k];
      iReqData1[k*W +: W] = db[k];
    end
  end

  function automatic logic [W-1:0] mulf(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [W-1:0] m);
    logic [2*W-1:0] p;
    if (m == '0) return '0;
    p = {32'b0, a} * {32'b0, b};
    return W'(p % {32'b0, m});
  endfunction

  function automatic logic [2*W-1:0] ucalc(input logic [W-1:0] m);
    logic [127:0] t;
    t = (128'd1 << 64) / {96'b0, m};
    return t[63:0];
  endfunction

  // External multiplier: L cycles from registered operands to iMulData.
  always @(posedge clk) begin
    for (int k = L-1; k > 0; k--) mpipe[k] <= mpipe[k-1];
    mpipe[0] <= mulf(oMulData0, oMulData1, oMulMod);
  end
  assign iMulData = mpipe[L-1];

  typedef struct {
    int         issue;
    int         req;
    logic [W-1:0] res;
  } op_t;

  op_t          m_q[$];
  int           m_state;
  int           m_ptr;
  logic [W-1:0] m_mod;
  logic [2*W-1:0] m_u;
  logic         exp_en, exp_clr;
  int           cyc;
  int           n_chk, n_pass;
  int           dut_rsp;
  logic [N-1:0] last_gnt;
  logic         cfg_done;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic rnd_data();
    for (int k = 0; k < N; k++) begin
      if (m_mod != '0) begin
        da[k] = $urandom % m_mod;
        db[k] = $urandom % m_mod;
      end else begin
        da[k] = $urandom;
        db[k] = $urandom;
      end
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = UNCFG;
    m_ptr   = 0;
    m_mod   = '0;
    m_u     = '0;
    exp_en  = 1'b0;
    exp_clr = 1'b1;
  endtask

  // One clock: check outputs at negedge, then advance the model.
  task automatic step();
    logic [N-1:0] ev, eg, v;
    logic [W-1:0] ed, a, b, cm;
    logic [2*W-1:0] cu;
    logic cv, r, cacc, rsp_now;
    int gi;
    @(negedge clk);
    ev = '0; ed = '0; rsp_now = 1'b0;
    if (oRspValid != '0) dut_rsp++;
    if (m_q.size() > 0 && m_q[0].issue + L + 1 == cyc) begin
      ev[m_q[0].req] = 1'b1;
      ed = m_q[0].res;
    end
    chk("rsp_valid", oRspValid, ev);
    if (ev != '0) begin
      chk("rsp_data", oRspData, ed);
      void'(m_q.pop_front());
      rsp_now = 1'b1;
    end
    chk("busy", oBusy, m_q.size() != 0);
    chk("mul_en", oMulEn, exp_en);
    chk("mul_clr", oMulClr, exp_clr);
    chk("mul_mod", oMulMod, m_mod);
    chk("mul_u", oMulU, m_u);
    v = iReqValid; cv = iCfgValid; r = iRstN;
    cm = iCfgMod; cu = iCfgU;
    eg = '0; gi = -1; cacc = 1'b0; a = '0; b = '0;
    case (m_state)
      UNCFG: cacc = cv;
      RUN: if (!cv) begin
        for (int k = 0; k < N; k++) begin
          if (gi < 0 && v[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
        end
      end
      default: cacc = cv && m_q.size() == 0 && !rsp_now;
    endcase
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      a = da[gi];
      b = db[gi];
    end
    chk("req_ready", oReqReady, eg);
    chk("cfg_ready", oCfgReady, cacc);
    last_gnt = oReqReady;
    @(posedge clk);
    #1;
    cyc++;
    cfg_done = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      exp_en  = 1'b1;
      exp_clr = cacc;
      cfg_done = cacc;
      if (gi >= 0) begin
        m_q.push_back('{cyc, gi, mulf(a, b, m_mod)});
        m_ptr = (gi + 1) % N;
      end
      if (cacc) begin
        m_mod = cm;
        m_u = cu;
        m_state = RUN;
      end else if (m_state == RUN && cv) begin
        m_state = DRAIN;
      end
    end
  endtask

  task automatic do_cfg(input logic [W-1:0] m, input string tag);
    logic got;
    iCfgValid = 1'b1;
    iCfgMod = m;
    iCfgU = ucalc(m);
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      step();
      got = cfg_done;
    end
    chk(tag, got, 1'b1);
    iCfgValid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    logic got;
    n_chk = 0; n_pass = 0; cyc = 0; dut_rsp = 0;
    cfg_done = 1'b0;
    for (int k = 0; k < L; k++) mpipe[k] = '0;
    for (int k = 0; k < N; k++) begin da[k] = '0; db[k] = '0; end
    iRstN = 1'b0;
    iReqValid = '1;
    iCfgValid = 1'b0;
    iCfgMod = '0;
    iCfgU = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_rsp_valid", oRspValid, 0);
    chk("rst_rsp_data", oRspData, 0);
    chk("rst_mul_a", oMulData0, 0);
    chk("rst_mul_b", oMulData1, 0);
    chk("rst_mod", oMulMod, 0);
    chk("rst_u", oMulU, 0);
    chk("rst_en", oMulEn, 0);
    chk("rst_clr", oMulClr, 1);
    chk("rst_busy", oBusy, 0);
    chk("rst_ready", oReqReady, 0);
    step();

    // Test 1: no grants while unconfigured, then load mod 7.
    iRstN = 1'b1;
    repeat (3) begin rnd_data(); step(); end
    iReqValid = '0;
    do_cfg(32'd7, "t1_cfg_acc");
    step();
    chk("t1_mod", oMulMod, 7);

    // Test 2: single op from requester 1.
    da[1] = 32'd3; db[1] = 32'd5;
    iReqValid = 4'b0010;
    base = dut_rsp;
    step();
    iReqValid = '0;
    repeat (12) step();
    chk("t2_rsp_cnt", dut_rsp - base, 1);

    // Test 3: all requesters streaming.
    iReqValid = 4'b1111;
    base = dut_rsp;
    repeat (12) begin rnd_data(); step(); end
    iReqValid = '0;
    repeat (13) step();
    chk("t3_rsp_cnt", dut_rsp - base, 12);

    // Test 4: reconfigure under load, drain, reconfigure.
    do_cfg(32'hFFFF_FFFF, "t4_cfg0_acc");
    chk("t4_u0", iCfgU, 64'h1_0000_0001);
    iReqValid = 4'b0100;
    base = dut_rsp;
    repeat (20) begin rnd_data(); step(); end
    iCfgValid = 1'b1;
    iCfgMod = 32'hFFFF_FFFB;
    iCfgU = ucalc(32'hFFFF_FFFB);
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      rnd_data();
      step();
      got = cfg_done;
    end
    chk("t4_cfg1_acc", got, 1'b1);
    chk("t4_old_rsp", dut_rsp - base, 20);
    iCfgValid = 1'b0;
    rnd_data();
    step();
    iReqValid = '0;
    repeat (13) step();
    chk("t4_total_rsp", dut_rsp - base, 21);

    // Test 5: reset with operations in flight.
    iReqValid = 4'b1111;
    repeat (5) begin rnd_data(); step(); end
    iReqValid = '0;
    iRstN = 1'b0;
    step();
    iRstN = 1'b1;
    iReqValid = 4'b1111;
    base = dut_rsp;
    repeat (20) step();
    chk("t5_no_rsp", dut_rsp - base, 0);
    chk("t5_busy", oBusy, 0);
    iReqValid = '0;

    // Test 6: pointer wraps from requester 3 back to 0.
    do_cfg(32'd7, "t6_cfg_acc");
    iReqValid = 4'b1000;
    rnd_data();
    step();
    chk("t6_first", last_gnt, 4'b1000);
    iReqValid = 4'b1001;
    rnd_data();
    step();
    chk("t6_wrap", last_gnt, 4'b0001);
    iReqValid = '0;
    repeat (13) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
